// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_e;

    // Iteration counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// One restoring-division trial step: WIDTH+1-bit subtract producing the low difference bits and the borrow.
module div_trial_sub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   minuend,
    input  logic [WIDTH:0]   subtrahend,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] full_diff;

    assign full_diff = minuend - subtrahend;
    assign diff      = full_diff[WIDTH-1:0];
    assign borrow    = full_diff[WIDTH];

endmodule

// File: rtl/div_restoring_seq.sv
// Multi-cycle restoring divider, one trial subtraction per cycle; results appear with a one-cycle done pulse.
// Define DIV_SIGNED_EN for two's-complement operands (sign fix-up applied on entry to DONE).
module div_restoring_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             ovfl
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_e       state;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;

    logic [WIDTH-1:0] trial_diff;
    logic             trial_borrow;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_result;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;

    wire accept    = (state == IDLE) && start;
    wire last_iter = (state == RUN) && (counter == CNT_W'(1));

    // The shifted partial remainder is {R, Q msb}; the extra bit keeps the borrow exact for large divisors.
    div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
        .minuend    ({r_reg, q_reg[WIDTH-1]}),
        .subtrahend ({1'b0, d_reg}),
        .diff       (trial_diff),
        .borrow     (trial_borrow)
    );

    always_comb begin
        q_next = {q_reg[WIDTH-2:0], ~trial_borrow};
        r_next = trial_borrow ? {r_reg[WIDTH-2:0], q_reg[WIDTH-1]} : trial_diff;
    end

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
    logic ovfl_pend;

    // The core divides magnitudes; signs are reapplied when the result is committed.
    assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign q_result     = neg_q ? -q_next : q_next;
    assign r_result     = neg_r ? -r_next : r_next;

    // MIN / -1 already yields quotient MIN from the magnitude path; only the flag needs remembering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            ovfl_pend <= 1'b0;
            ovfl      <= 1'b0;
        end else if (accept) begin
            if (divisor == '0) begin
                ovfl <= 1'b0;
            end else begin
                neg_q     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                neg_r     <= dividend[WIDTH-1];
                ovfl_pend <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
            end
        end else if (last_iter) begin
            ovfl <= ovfl_pend;
        end
    end
`else
    assign dividend_mag = dividend;
    assign divisor_mag  = divisor;
    assign q_result     = q_next;
    assign r_result     = r_next;
    assign ovfl         = 1'b0;
`endif

    // Outputs are only written on the edge that enters DONE, so they hold steady through RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= '0;
            r_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state   <= RUN;
                            busy    <= 1'b1;
                            counter <= CNT_W'(WIDTH);
                            r_reg   <= '0;
                            q_reg   <= dividend_mag;
                            d_reg   <= divisor_mag;
                        end
                    end
                end
                RUN: begin
                    r_reg   <= r_next;
                    q_reg   <= q_next;
                    counter <= counter - CNT_W'(1);
                    if (last_iter) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_result;
                        remainder   <= r_result;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_restoring_seq.sv
// Self-checking bench for div_restoring_seq: arithmetic reference model compared every cycle plus literal result checks.
module tb_div_restoring_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         ovfl;

    int errors = 0;
    int checks = 0;

    int           m_phase = 0;
    int           m_left = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic         exp_busy = 1'b0;
    logic         exp_done = 1'b0;
    logic [W-1:0] exp_q = '0;
    logic [W-1:0] exp_r = '0;
    logic         exp_dbz = 1'b0;
    logic         exp_ovfl = 1'b0;

    always #5 clk = ~clk;

    div_restoring_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .ovfl        (ovfl)
    );

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Plain arithmetic reference: / and % truncate toward zero with the remainder taking the dividend's sign.
    function automatic void model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] q, output logic [W-1:0] r,
                                      output logic ov);
`ifdef DIV_SIGNED_EN
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sa == -(1 << (W - 1)) && sb == -1) begin
            q  = {1'b1, {(W-1){1'b0}}};
            r  = '0;
            ov = 1'b1;
        end else begin
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            ov = 1'b0;
        end
`else
        q  = a / b;
        r  = a % b;
        ov = 1'b0;
`endif
    endfunction

    // Transaction-level timing model: accept in IDLE, W busy cycles, one done cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase  = 0;
            m_left   = 0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_q    = '0;
            exp_r    = '0;
            exp_dbz  = 1'b0;
            exp_ovfl = 1'b0;
        end else begin
            exp_done = 1'b0;
            case (m_phase)
                0: begin
                    if (start) begin
                        if (divisor == '0) begin
                            m_phase  = 2;
                            exp_done = 1'b1;
                            exp_q    = '1;
                            exp_r    = dividend;
                            exp_dbz  = 1'b1;
                            exp_ovfl = 1'b0;
                        end else begin
                            m_phase  = 1;
                            m_left   = W;
                            exp_busy = 1'b1;
                            m_a      = dividend;
                            m_b      = divisor;
                        end
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase  = 2;
                        exp_busy = 1'b0;
                        exp_done = 1'b1;
                        exp_dbz  = 1'b0;
                        model_div(m_a, m_b, exp_q, exp_r, exp_ovfl);
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        checkOutput("busy", busy, exp_busy);
        checkOutput("done", done, exp_done);
        checkOutput("quotient", quotient, exp_q);
        checkOutput("remainder", remainder, exp_r);
        checkOutput("div_by_zero", div_by_zero, exp_dbz);
        checkOutput("ovfl", ovfl, exp_ovfl);
    end

    // Leaves the bench at the negedge of cycle 1 (the first cycle after the start cycle).
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic waitDone(input string name, input int cyc0, input int exp_lat);
        int cyc;
        cyc = cyc0;
        while (done !== 1'b1 && cyc < 3 * W) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({name, " latency"}, W'(cyc), W'(exp_lat));
    endtask

    task automatic runOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q_lit, input logic [W-1:0] r_lit, input logic dbz_lit);
        applyStimulus(a, b);
        waitDone(name, 1, (b == '0) ? 1 : W + 1);
        checkOutput({name, " Q"}, quotient, q_lit);
        checkOutput({name, " R"}, remainder, r_lit);
        checkOutput({name, " dbz"}, div_by_zero, dbz_lit);
        @(negedge clk);
    endtask

    initial begin
        int saw_done;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset Q", quotient, '0);
        checkOutput("reset R", remainder, '0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(16'd100, 16'd7);
        checkOutput("100/7 busy cycle1", busy, 1'b1);
        checkOutput("100/7 Q held during run", quotient, '0);
        waitDone("100/7", 1, W + 1);
        checkOutput("100/7 Q", quotient, 16'd14);
        checkOutput("100/7 R", remainder, 16'd2);
        checkOutput("100/7 dbz", div_by_zero, 1'b0);
        @(negedge clk);

        runOp("FFFF/1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0);
        runOp("3/9", 16'h0003, 16'h0009, 16'h0000, 16'h0003, 1'b0);
        runOp("FFFF/8001", 16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0);
        runOp("1000/1000", 16'd1000, 16'd1000, 16'd1, 16'd0, 1'b0);
        runOp("0/5", 16'd0, 16'd5, 16'd0, 16'd0, 1'b0);

        applyStimulus(16'h1234, 16'h0000);
        checkOutput("dbz busy cycle1", busy, 1'b0);
        waitDone("dbz", 1, 1);
        checkOutput("dbz Q", quotient, 16'hFFFF);
        checkOutput("dbz R", remainder, 16'h1234);
        checkOutput("dbz flag", div_by_zero, 1'b1);
        @(negedge clk);

        // A second start mid-run must be dropped.
        applyStimulus(16'd100, 16'd7);
        repeat (4) @(negedge clk);
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
        @(negedge clk);
        start    = 1'b0;
        waitDone("ignored start", 6, W + 1);
        checkOutput("ignored start Q", quotient, 16'd14);
        checkOutput("ignored start R", remainder, 16'd2);
        repeat (3) @(negedge clk);

        // Reset during busy cycle 8.
        applyStimulus(16'hABCD, 16'd3);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid rst busy", busy, 1'b0);
        checkOutput("mid rst Q", quotient, '0);
        checkOutput("mid rst R", remainder, '0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done === 1'b1) saw_done++;
        end
        checkOutput("no done after rst", W'(saw_done), '0);
        runOp("after rst 3/9", 16'h0003, 16'h0009, 16'h0000, 16'h0003, 1'b0);

`ifdef DIV_SIGNED_EN
        runOp("-7/2", 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0);
        runOp("7/-2", 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0);
        applyStimulus(16'h8000, 16'hFFFF);
        waitDone("MIN/-1", 1, W + 1);
        checkOutput("MIN/-1 Q", quotient, 16'h8000);
        checkOutput("MIN/-1 R", remainder, 16'h0000);
        checkOutput("MIN/-1 ovfl", ovfl, 1'b1);
        @(negedge clk);
`else
        runOp("FFF9/2", 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0);
        checkOutput("unsigned ovfl", ovfl, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
